// File: rtl/ram_wb_pkg.sv
// Shared definitions for the Wishbone burst master: cycle-type codes, burst type and FSM encoding.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package ram_wb_pkg;

  // Wishbone B3 cycle type identifiers
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Burst type extension: only linear bursts are issued
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  // Master FSM state encoding
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = IDLE,
    S_RD   = RD,
    S_WR   = WR,
    S_DONE = DONE
  } state_t;

endpackage

// File: rtl/ram_wb_burst_master_if.sv
// Wishbone B3 bus bundle between the burst master and a word-wide SRAM-style slave.
// Latency: n/a (wires only).
// Backpressure: slave stalls the master by withholding ack_i.
// Ports (master view): adr_o word address, dat_o/dat_i write/read data, we_o, sel_o, cyc_o, stb_o,
//   cti_o cycle type, bte_o burst type, ack_i acknowledge.
interface ram_wb_burst_master_if #(
  parameter int ADR_WIDTH = 13
);
  logic [ADR_WIDTH-3:0] adr_o;
  logic [31:0]          dat_o;
  logic [31:0]          dat_i;
  logic                 we_o;
  logic [3:0]           sel_o;
  logic                 cyc_o;
  logic                 stb_o;
  logic [2:0]           cti_o;
  logic [1:0]           bte_o;
  logic                 ack_i;

  modport master (
    output adr_o, dat_o, we_o, sel_o, cyc_o, stb_o, cti_o, bte_o,
    input  dat_i, ack_i
  );

  modport slave (
    input  adr_o, dat_o, we_o, sel_o, cyc_o, stb_o, cti_o, bte_o,
    output dat_i, ack_i
  );
endinterface

// File: rtl/ram_wb_watchdog.sv
// Stall watchdog: counts enabled cycles and pulses tc on the TIMEOUT-th consecutive one.
// Latency: tc is combinational in the cycle the count would reach TIMEOUT.
// Backpressure: none; clr wins over en and restarts the count.
// Ports: clk_i, rst_n_i (async, active-low), en count enable, clr synchronous clear, tc terminal count.
module ram_wb_watchdog #(
  parameter int TO_WIDTH = 8,
  parameter int TIMEOUT  = 255
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic en,
  input  logic clr,
  output logic tc
);
  logic [TO_WIDTH-1:0] cnt;

  // cnt holds the number of stalled cycles already seen, so the current one is cnt+1
  assign tc = en & (cnt == TO_WIDTH'(TIMEOUT - 1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt <= '0;
    end else if (clr || tc) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + TO_WIDTH'(1);
    end
  end
endmodule

// File: rtl/ram_wb_burst_master.sv
// Wishbone B3 burst initiator: one local command becomes a classic or incrementing burst cycle.
// Latency: cyc_o rises the cycle after command capture; done_o pulses the cycle after the last ack.
// Backpressure: slave via ack_i (watchdog-bounded); write source via wdata_ready_o; read stream has none.
// Ports: clk_i/rst_n_i; cmd_* command handshake (cmd_ready_o high only in IDLE); wdata_* write
//   stream; rdata_o/rdata_valid_o read stream; done_o/err_o completion; wb Wishbone master bundle.
module ram_wb_burst_master
  import ram_wb_pkg::*;
#(
  parameter int ADR_WIDTH = 13,
  parameter int LEN_WIDTH = 4,
  parameter int TIMEOUT   = 255,
  parameter int TO_WIDTH  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_we_i,
  input  logic [ADR_WIDTH-3:0] cmd_adr_i,
  input  logic [LEN_WIDTH-1:0] cmd_len_i,
  input  logic [3:0]           cmd_sel_i,
  input  logic [31:0]          wdata_i,
  input  logic                 wdata_valid_i,
  output logic                 wdata_ready_o,
  output logic [31:0]          rdata_o,
  output logic                 rdata_valid_o,
  output logic                 done_o,
  output logic                 err_o,
  ram_wb_burst_master_if.master wb
);
  localparam int AW = ADR_WIDTH - 2;

  state_t               state;
  logic [LEN_WIDTH-1:0] beats;       // beats remaining after the current one
  logic [LEN_WIDTH:0]   loads_left;  // write beats not yet pulled from the source
  logic                 beat_ack;
  logic                 last_beat;
  logic                 wdata_load;
  logic                 wd_en;
  logic                 wd_clr;
  logic                 wd_tc;

  assign beat_ack    = wb.stb_o & wb.ack_i;  // ack with stb low is ignored
  assign last_beat   = beat_ack & (beats == '0);
  assign cmd_ready_o = (state == S_IDLE);
  assign wb.bte_o    = BTE_LINEAR;

  // Combinational on ack_i so a new beat can be loaded in the same edge the old one is acked,
  // keeping stb_o high across back-to-back write beats.
  assign wdata_ready_o = (state == S_WR) & (loads_left != '0) & (~wb.stb_o | wb.ack_i);
  assign wdata_load    = wdata_valid_i & wdata_ready_o;

  assign wd_en  = wb.stb_o & ~wb.ack_i;
  assign wd_clr = ~wb.stb_o | wb.ack_i;

  ram_wb_watchdog #(
    .TO_WIDTH (TO_WIDTH),
    .TIMEOUT  (TIMEOUT)
  ) u_watchdog (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en      (wd_en),
    .clr     (wd_clr),
    .tc      (wd_tc)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state         <= S_IDLE;
      beats         <= '0;
      loads_left    <= '0;
      wb.adr_o      <= '0;
      wb.dat_o      <= '0;
      wb.we_o       <= 1'b0;
      wb.sel_o      <= '0;
      wb.cyc_o      <= 1'b0;
      wb.stb_o      <= 1'b0;
      wb.cti_o      <= CTI_CLASSIC;
      rdata_o       <= '0;
      rdata_valid_o <= 1'b0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      rdata_valid_o <= 1'b0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;

      case (state)
        S_IDLE: begin
          if (cmd_valid_i) begin
            wb.adr_o   <= cmd_adr_i;
            wb.sel_o   <= cmd_sel_i;
            wb.we_o    <= cmd_we_i;
            wb.cyc_o   <= 1'b1;
            // reads strobe immediately; writes wait for the first data beat
            wb.stb_o   <= ~cmd_we_i;
            wb.cti_o   <= (cmd_len_i == '0) ? CTI_CLASSIC : CTI_INCR;
            beats      <= cmd_len_i;
            loads_left <= {1'b0, cmd_len_i} + (LEN_WIDTH + 1)'(1);
            state      <= cmd_we_i ? S_WR : S_RD;
          end
        end

        S_RD, S_WR: begin
          if (wd_tc) begin
            // slave never answered: abandon the remaining beats
            wb.cyc_o <= 1'b0;
            wb.stb_o <= 1'b0;
            wb.we_o  <= 1'b0;
            done_o   <= 1'b1;
            err_o    <= 1'b1;
            state    <= S_DONE;
          end else begin
            if (beat_ack) begin
              wb.adr_o <= wb.adr_o + AW'(1);
              if (state == S_RD) begin
                rdata_o       <= wb.dat_i;
                rdata_valid_o <= 1'b1;
              end
              // one beat left after this ack: the next beat is the last of an incrementing burst
              if (beats == LEN_WIDTH'(1)) begin
                wb.cti_o <= CTI_EOB;
              end
              if (beats != '0) begin
                beats <= beats - LEN_WIDTH'(1);
              end
            end

            if (last_beat) begin
              wb.cyc_o <= 1'b0;
              wb.stb_o <= 1'b0;
              wb.we_o  <= 1'b0;
              done_o   <= 1'b1;
              state    <= S_DONE;
            end else if (wdata_load) begin
              wb.dat_o   <= wdata_i;
              wb.stb_o   <= 1'b1;
              loads_left <= loads_left - (LEN_WIDTH + 1)'(1);
            end else if (beat_ack && (state == S_WR)) begin
              // no data ready: insert a master wait state, cyc_o and cti_o held
              wb.stb_o <= 1'b0;
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ram_wb_burst_master.sv
`timescale 1ns/1ps
module tb_ram_wb_burst_master;
  localparam int ADR_WIDTH = 13;
  localparam int LEN_WIDTH = 4;
  localparam int TIMEOUT   = 255;
  localparam int TO_WIDTH  = 8;
  localparam int AW        = ADR_WIDTH - 2;

  logic                 clk_i = 1'b0;
  logic                 rst_n_i = 1'b0;
  logic                 cmd_valid_i = 1'b0;
  logic                 cmd_ready_o;
  logic                 cmd_we_i = 1'b0;
  logic [AW-1:0]        cmd_adr_i = '0;
  logic [LEN_WIDTH-1:0] cmd_len_i = '0;
  logic [3:0]           cmd_sel_i = '0;
  logic [31:0]          wdata_i = '0;
  logic                 wdata_valid_i = 1'b0;
  logic                 wdata_ready_o;
  logic [31:0]          rdata_o;
  logic                 rdata_valid_o;
  logic                 done_o;
  logic                 err_o;

  ram_wb_burst_master_if #(.ADR_WIDTH(ADR_WIDTH)) wb ();

  ram_wb_burst_master #(
    .ADR_WIDTH (ADR_WIDTH),
    .LEN_WIDTH (LEN_WIDTH),
    .TIMEOUT   (TIMEOUT),
    .TO_WIDTH  (TO_WIDTH)
  ) dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .cmd_valid_i   (cmd_valid_i),
    .cmd_ready_o   (cmd_ready_o),
    .cmd_we_i      (cmd_we_i),
    .cmd_adr_i     (cmd_adr_i),
    .cmd_len_i     (cmd_len_i),
    .cmd_sel_i     (cmd_sel_i),
    .wdata_i       (wdata_i),
    .wdata_valid_i (wdata_valid_i),
    .wdata_ready_o (wdata_ready_o),
    .rdata_o       (rdata_o),
    .rdata_valid_o (rdata_valid_o),
    .done_o        (done_o),
    .err_o         (err_o),
    .wb            (wb)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- slave RAM: decides ack at negedge for the coming edge ----------------
  logic [31:0] mem [0:(1<<AW)-1];
  int  slv_wait = 0;
  bit  slv_never = 0;
  bit  slv_spurious = 0;
  int  stb_wait = 0;

  always @(negedge clk_i) begin
    if (wb.cyc_o && wb.stb_o && !slv_never) begin
      if (wb.ack_i) stb_wait = 0;
      if (stb_wait >= slv_wait) begin
        wb.ack_i = 1'b1;
        if (wb.we_o) begin
          for (int b = 0; b < 4; b++)
            if (wb.sel_o[b]) mem[wb.adr_o][8*b +: 8] = wb.dat_o[8*b +: 8];
        end
        wb.dat_i = mem[wb.adr_o];
      end else begin
        wb.ack_i = 1'b0;
        wb.dat_i = 32'hDEAD_BEEF;
        stb_wait++;
      end
    end else begin
      wb.ack_i = wb.cyc_o && !wb.stb_o && slv_spurious;
      wb.dat_i = 32'hDEAD_BEEF;
      stb_wait = 0;
    end
  end

  // ---------------- write data source ----------------
  logic [31:0] wq[$];
  logic [31:0] popped;
  int  gap_after = -1;
  int  gap_len = 0;
  int  gap_cnt = 0;
  int  pops = 0;
  bit  wfire = 0;

  always @(negedge clk_i) begin
    if (wfire && wq.size() > 0) begin
      popped = wq.pop_front();
      pops++;
      if (pops == gap_after) gap_cnt = gap_len;
    end
    wfire = 0;
    if (gap_cnt > 0) begin
      wdata_valid_i = 1'b0;
      gap_cnt--;
    end else if (wq.size() > 0) begin
      wdata_valid_i = 1'b1;
      wdata_i = wq[0];
    end else begin
      wdata_valid_i = 1'b0;
    end
  end

  // ---------------- transaction-level model + per-cycle compare ----------------
  logic [31:0]   exp_wd [16];
  bit            m_active = 0, m_done = 0, m_err = 0, m_rv = 0;
  bit            nd, nrv;
  logic [31:0]   m_rexp;
  logic          m_we;
  logic [AW-1:0] m_adr, m_ea;
  logic [3:0]    m_sel;
  int            m_len, m_k, m_stall, m_loads;

  logic [AW-1:0] log_adr[$];
  logic [2:0]    log_cti[$];
  int            done_cnt = 0, rv_cnt = 0, stb_hi_cnt = 0, stall_lo_cnt = 0;
  logic          last_err = 1'b0;
  logic [31:0]   last_rdata = '0;

  function automatic logic [2:0] exp_cti(input int len, input int k);
    if (len == 0) return 3'b000;
    return (k == len) ? 3'b111 : 3'b010;
  endfunction

  always begin
    @(negedge clk_i);
    #2;
    if (!rst_n_i) begin
      m_active = 0; m_done = 0; m_rv = 0; m_stall = 0;
      chk("rst_cyc", wb.cyc_o, 0);
      chk("rst_stb", wb.stb_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_rvalid", rdata_valid_o, 0);
      chk("rst_wrdy", wdata_ready_o, 0);
    end else begin
      chk("cmd_ready", cmd_ready_o, !m_active && !m_done);
      chk("cyc", wb.cyc_o, m_active);
      chk("bte", wb.bte_o, 0);
      chk("done", done_o, m_done);
      if (m_done) chk("err", err_o, m_err);
      chk("rvalid", rdata_valid_o, m_rv);
      if (m_rv) chk("rdata", rdata_o, m_rexp);
      if (done_o) begin done_cnt++; last_err = err_o; end
      if (rdata_valid_o) begin rv_cnt++; last_rdata = rdata_o; end
      if (m_active) begin
        m_ea = m_adr + AW'(m_k);
        chk("adr", wb.adr_o, m_ea);
        chk("cti", wb.cti_o, exp_cti(m_len, m_k));
        chk("we", wb.we_o, m_we);
        chk("sel", wb.sel_o, m_sel);
        chk("wrdy", wdata_ready_o,
            m_we && (m_loads <= m_len) && (!wb.stb_o || wb.ack_i));
        if (wb.stb_o && m_we) chk("dat_o", wb.dat_o, exp_wd[m_k]);
        if (wb.stb_o) stb_hi_cnt++; else stall_lo_cnt++;
      end else begin
        chk("stb_idle", wb.stb_o, 0);
      end
      wfire = wdata_valid_i && wdata_ready_o;

      nd = 0; nrv = 0;
      if (m_active) begin
        if (wfire) m_loads++;
        if (wb.stb_o && wb.ack_i) begin
          log_adr.push_back(wb.adr_o);
          log_cti.push_back(wb.cti_o);
          m_stall = 0;
          if (!m_we) begin nrv = 1; m_rexp = wb.dat_i; end
          if (m_k == m_len) begin m_active = 0; nd = 1; m_err = 0; end
          else m_k++;
        end else if (wb.stb_o) begin
          m_stall++;
          if (m_stall == TIMEOUT) begin m_active = 0; nd = 1; m_err = 1; end
        end else begin
          m_stall = 0;
        end
      end else if (!m_done && cmd_valid_i) begin
        m_active = 1; m_we = cmd_we_i; m_adr = cmd_adr_i; m_len = int'(cmd_len_i);
        m_sel = cmd_sel_i; m_k = 0; m_stall = 0; m_loads = 0;
      end
      m_done = nd;
      m_rv = nrv;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clr_obs();
    log_adr.delete(); log_cti.delete();
    rv_cnt = 0; stb_hi_cnt = 0; stall_lo_cnt = 0;
  endtask

  task automatic issue(input bit we, input logic [AW-1:0] adr, input int len, input logic [3:0] sel);
    @(negedge clk_i);
    cmd_valid_i = 1'b1; cmd_we_i = we; cmd_adr_i = adr;
    cmd_len_i = LEN_WIDTH'(len); cmd_sel_i = sel;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string name, input int d0);
    for (int i = 0; i < 600; i++) begin
      @(negedge clk_i);
      #3;
      if (done_cnt != d0) return;
    end
    vectors++; miscompares++;
    $display("FAIL %s_timeout: no done_o within 600 cycles", name);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "hang");
  end

  logic [2:0] cti4 [4];
  int d0;

  initial begin
    wb.ack_i = 1'b0;
    wb.dat_i = '0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h5A00_0000 | i;
    cti4[0] = 3'b010; cti4[1] = 3'b010; cti4[2] = 3'b010; cti4[3] = 3'b111;

    // reset state
    repeat (3) @(negedge clk_i);
    #3;
    chk("reset_cyc", wb.cyc_o, 0);
    chk("reset_stb", wb.stb_o, 0);
    chk("reset_we", wb.we_o, 0);
    chk("reset_adr", wb.adr_o, 0);
    chk("reset_dat", wb.dat_o, 0);
    chk("reset_sel", wb.sel_o, 0);
    chk("reset_cti", wb.cti_o, 0);
    chk("reset_rdata", rdata_o, 0);
    chk("reset_err", err_o, 0);
    chk("reset_cmd_ready", cmd_ready_o, 1);
    @(negedge clk_i);
    rst_n_i = 1'b1;

    // (1) single read, one wait state
    mem[11'h010] = 32'h1234_5678;
    slv_wait = 1; clr_obs(); d0 = done_cnt;
    issue(1'b0, 11'h010, 0, 4'hF);
    wait_done("s1", d0);
    chk("s1_rdata", last_rdata, 32'h1234_5678);
    chk("s1_rv_cnt", rv_cnt, 1);
    chk("s1_err", last_err, 0);
    chk("s1_nbeats", log_cti.size(), 1);
    if (log_cti.size() == 1) chk("s1_cti", log_cti[0], 3'b000);

    // (2) 4-beat write, data always valid, ack every cycle
    slv_wait = 0; clr_obs();
    for (int i = 0; i < 4; i++) begin exp_wd[i] = 32'hA0 + i; wq.push_back(32'hA0 + i); end
    d0 = done_cnt;
    issue(1'b1, 11'h020, 3, 4'hF);
    wait_done("s2", d0);
    chk("s2_err", last_err, 0);
    chk("s2_stall_cycles", stall_lo_cnt, 1);
    chk("s2_nbeats", log_adr.size(), 4);
    if (log_adr.size() == 4)
      for (int i = 0; i < 4; i++) begin
        chk("s2_adr", log_adr[i], 11'h020 + i);
        chk("s2_cti", log_cti[i], cti4[i]);
      end
    for (int i = 0; i < 4; i++) chk("s2_ram", mem[11'h020 + i], 32'hA0 + i);

    // (3) 4-beat write with a 2-cycle data gap after beat 1, spurious acks while stb is low
    clr_obs(); pops = 0; gap_after = 1; gap_len = 2; slv_spurious = 1;
    for (int i = 0; i < 4; i++) begin exp_wd[i] = 32'hB0 + i; wq.push_back(32'hB0 + i); end
    d0 = done_cnt;
    issue(1'b1, 11'h030, 3, 4'hF);
    wait_done("s3", d0);
    slv_spurious = 0; gap_after = -1;
    chk("s3_stall_cycles", stall_lo_cnt, 3);
    chk("s3_nbeats", log_adr.size(), 4);
    if (log_cti.size() == 4)
      for (int i = 0; i < 4; i++) chk("s3_cti", log_cti[i], cti4[i]);
    for (int i = 0; i < 4; i++) chk("s3_ram", mem[11'h030 + i], 32'hB0 + i);

    // (4) 8-beat read, slave never acks; a stray command mid-cycle must be ignored
    clr_obs(); slv_never = 1; d0 = done_cnt;
    issue(1'b0, 11'h050, 7, 4'hF);
    repeat (10) @(negedge clk_i);
    cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_adr_i = 11'h060; cmd_len_i = '0;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    wait_done("s4", d0);
    slv_never = 0;
    chk("s4_stb_cycles", stb_hi_cnt, TIMEOUT);
    chk("s4_err", last_err, 1);
    chk("s4_rv_cnt", rv_cnt, 0);
    chk("s4_nbeats", log_adr.size(), 0);
    repeat (3) @(negedge clk_i);
    #3;
    chk("s4_no_new_cycle", done_cnt - d0, 1);
    chk("s4_idle_cyc", wb.cyc_o, 0);

    // (5) reset during beat 2 of a 4-beat read, then a clean read
    clr_obs(); slv_wait = 1;
    issue(1'b0, 11'h040, 3, 4'hF);
    for (int i = 0; i < 40 && log_adr.size() < 1; i++) begin @(negedge clk_i); #3; end
    chk("s5_first_beat", log_adr.size(), 1);
    @(negedge clk_i);
    #5;
    rst_n_i = 1'b0;
    #1;
    chk("s5_async_cyc", wb.cyc_o, 0);
    chk("s5_async_stb", wb.stb_o, 0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    #3;
    chk("s5_cmd_ready", cmd_ready_o, 1);
    mem[11'h070] = 32'hC000_0000; mem[11'h071] = 32'hC000_0001;
    clr_obs(); d0 = done_cnt;
    issue(1'b0, 11'h070, 1, 4'hF);
    wait_done("s5", d0);
    chk("s5_err", last_err, 0);
    chk("s5_rv_cnt", rv_cnt, 2);
    chk("s5_rdata_last", last_rdata, 32'hC000_0001);

    // (6) 2-beat read wrapping the top of the address space
    mem[11'h7FF] = 32'hD000_07FF; mem[11'h000] = 32'hD000_0000;
    clr_obs(); slv_wait = 0; d0 = done_cnt;
    issue(1'b0, 11'h7FF, 1, 4'hF);
    wait_done("s6", d0);
    chk("s6_nbeats", log_adr.size(), 2);
    if (log_adr.size() == 2) begin
      chk("s6_adr0", log_adr[0], 11'h7FF);
      chk("s6_adr1", log_adr[1], 11'h000);
      chk("s6_cti0", log_cti[0], 3'b010);
      chk("s6_cti1", log_cti[1], 3'b111);
    end
    chk("s6_rdata_last", last_rdata, 32'hD000_0000);

    repeat (3) @(negedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
